// File: rtl/bcd_display_sequencer.sv
// rtl/bcd_display_sequencer.sv - iterative binary-to-BCD converter with multiplexed 7-seg scan
//   clk, reset        : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake, in_data = 13-bit unsigned value
//   busy, done        : conversion in progress, one-cycle commit pulse
//   bcd               : committed digits {thousands,hundreds,tens,ones}
//   disp_en           : 0 forces all anodes off while scanning continues
//   anode, seg        : active-low digit enables and segments {a,b,c,d,e,f,g}
module bcd_display_sequencer #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [12:0] in_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd,
    input  logic        disp_en,
    output logic [3:0]  anode,
    output logic [6:0]  seg
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [28:0]   shift_q, shift_d;
    logic [15:0]   bcd_q, bcd_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    anode_q, anode_d;
    logic [6:0]    seg_q, seg_d;

    logic [28:0]   adj;
    logic [28:0]   shifted;
    logic [3:0]    digit;
    logic          blank3, blank2, blank1, blank_cur;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign bcd      = bcd_q;
    assign anode    = anode_q;
    assign seg      = seg_q;

    // Double-dabble step: BCD nibbles sit at [28:13], binary remainder at [12:0].
    always_comb begin
        adj = shift_q;
        for (int i = 0; i < 4; i++) begin
            if (adj[13 + 4*i +: 4] >= 4'd5) begin
                adj[13 + 4*i +: 4] = adj[13 + 4*i +: 4] + 4'd3;
            end
        end
        shifted = adj << 1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    shift_d = {16'b0, in_data};
                    cnt_d   = 4'd0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_d = shifted;
                cnt_d   = cnt_q + 4'd1;
                // Thirteenth shift: digits are final, commit them all at once.
                if (cnt_q == 4'd12) begin
                    bcd_d   = shifted[28:13];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Scan path runs freely; anode and seg are registered together from the
    // same (index, bcd) snapshot so a digit never shows another digit's segments.
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end

        blank3 = BLANK_LZ && (bcd_q[15:12] == 4'd0);
        blank2 = blank3 && (bcd_q[11:8] == 4'd0);
        blank1 = blank2 && (bcd_q[7:4] == 4'd0);

        case (idx_q)
            2'd0: begin
                digit     = bcd_q[3:0];
                blank_cur = 1'b0;
            end
            2'd1: begin
                digit     = bcd_q[7:4];
                blank_cur = blank1;
            end
            2'd2: begin
                digit     = bcd_q[11:8];
                blank_cur = blank2;
            end
            default: begin
                digit     = bcd_q[15:12];
                blank_cur = blank3;
            end
        endcase

        seg_d   = blank_cur ? SEG_BLANK : seg7(digit);
        anode_d = disp_en ? ~(4'b0001 << idx_q) : 4'b1111;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            shift_q <= '0;
            bcd_q   <= 16'h0000;
            presc_q <= '0;
            idx_q   <= 2'd0;
            anode_q <= 4'b1110;
            seg_q   <= 7'b0000001;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
        end
    end

endmodule
